// File: rtl/asym_ram_pkg.sv
// rtl/asym_ram_pkg.sv - default geometry and shared types for the asymmetric SDP RAM
package asym_ram_pkg;

    localparam int WIDTHA_DEF     = 16;
    localparam int SIZEA_DEF      = 256;
    localparam int ADDRWIDTHA_DEF = 8;
    localparam int WIDTHB_DEF     = 8;
    localparam int SIZEB_DEF      = 512;
    localparam int ADDRWIDTHB_DEF = 9;

    localparam int RATIO_DEF      = WIDTHA_DEF / WIDTHB_DEF;
    localparam int LOG2_RATIO_DEF = $clog2(RATIO_DEF);

    typedef logic [WIDTHB_DEF-1:0] narrow_word_t;

endpackage

// File: rtl/asym_ram_sdp_write_wider.sv
// rtl/asym_ram_sdp_write_wider.sv - wide-write / narrow-read SDP RAM, optional ASYM_RAM_OUT_REG_EN output stage
module asym_ram_sdp_write_wider
    import asym_ram_pkg::*;
#(
    parameter int WIDTHA     = WIDTHA_DEF,
    parameter int SIZEA      = SIZEA_DEF,
    parameter int ADDRWIDTHA = ADDRWIDTHA_DEF,
    parameter int WIDTHB     = WIDTHB_DEF,
    parameter int SIZEB      = SIZEB_DEF,
    parameter int ADDRWIDTHB = ADDRWIDTHB_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enaA,
    input  logic                  weA,
    input  logic [ADDRWIDTHA-1:0] addrA,
    input  logic [WIDTHA-1:0]     diA,
    input  logic                  enaB,
    input  logic [ADDRWIDTHB-1:0] addrB,
    output logic [WIDTHB-1:0]     doB
);

    localparam int RATIO = WIDTHA / WIDTHB;
    localparam int LOG2R = $clog2(RATIO);

    if ((SIZEA * WIDTHA != SIZEB * WIDTHB) || (ADDRWIDTHB != ADDRWIDTHA + LOG2R)
        || ((1 << LOG2R) != RATIO)) begin : g_bad_cfg
        $error("asym_ram_sdp_write_wider: unsupported width/depth combination");
    end

    logic [WIDTHB-1:0] mem_q [SIZEB];
    logic [WIDTHB-1:0] rd_q;
    logic [WIDTHB-1:0] rd_d;

    // Read register next value: sample the old array contents (read-first) or hold.
    always_comb begin
        rd_d = rd_q;
        if (enaB) begin
            rd_d = mem_q[addrB];
        end
    end

    // Storage and read register; a wide write fans out over RATIO little-endian byte lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < SIZEB; e++) begin
                mem_q[e] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (enaA && weA) begin
                for (int i = 0; i < RATIO; i++) begin
                    mem_q[{addrA, LOG2R'(i)}] <= diA[i*WIDTHB +: WIDTHB];
                end
            end
            rd_q <= rd_d;
        end
    end

`ifdef ASYM_RAM_OUT_REG_EN
    logic [WIDTHB-1:0] out_q;
    logic              rd_vld_q;

    // Output pipeline stage: reloads on the cycle after the read register was enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= enaB;
            if (rd_vld_q) begin
                out_q <= rd_q;
            end
        end
    end

    assign doB = out_q;
`else
    assign doB = rd_q;
`endif

endmodule

// File: tb/tb_asym_ram_sdp_write_wider.sv
// tb/tb_asym_ram_sdp_write_wider.sv - randomized and directed bench for asym_ram_sdp_write_wider
module tb_asym_ram_sdp_write_wider;

    logic        clk;
    logic        rst_n;
    logic        enaA;
    logic        weA;
    logic [7:0]  addrA;
    logic [15:0] diA;
    logic        enaB;
    logic [8:0]  addrB;
    logic [7:0]  doB;

    int passed;
    int total;

    logic [7:0] ref_mem [512];
    logic [7:0] exp_rd;
    logic [7:0] exp_out;
    logic       exp_prev_en;

    asym_ram_sdp_write_wider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .enaA  (enaA),
        .weA   (weA),
        .addrA (addrA),
        .diA   (diA),
        .enaB  (enaB),
        .addrB (addrB),
        .doB   (doB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] visible();
`ifdef ASYM_RAM_OUT_REG_EN
        return exp_out;
`else
        return exp_rd;
`endif
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 512; k++) ref_mem[k] = 8'h00;
        exp_rd      = 8'h00;
        exp_out     = 8'h00;
        exp_prev_en = 1'b0;
    endfunction

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic cycle(input logic ea, input logic we, input logic [7:0] aa,
                         input logic [15:0] da, input logic eb, input logic [8:0] ab,
                         input string tag);
        logic [7:0] new_rd;
        enaA = ea; weA = we; addrA = aa; diA = da; enaB = eb; addrB = ab;
        @(posedge clk);
        new_rd = eb ? ref_mem[ab] : exp_rd;
        if (exp_prev_en) exp_out = exp_rd;
        exp_prev_en = eb;
        exp_rd = new_rd;
        if (ea && we) begin
            ref_mem[{aa, 1'b0}] = da[7:0];
            ref_mem[{aa, 1'b1}] = da[15:8];
        end
        #1;
        check(tag, doB, visible());
    endtask

    task automatic read_settle(input logic [8:0] ab, input logic [7:0] want, input string tag);
        cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, ab, tag);
        cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, ab, tag);
        check({tag, "_const"}, doB, want);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        model_reset();
        rst_n = 1'b0;
        enaA = 1'b0; weA = 1'b0; addrA = '0; diA = '0; enaB = 1'b0; addrB = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_doB", doB, 8'h00);
        #2 rst_n = 1'b1;

        for (int a = 0; a < 512; a++) begin
            cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 9'(a), "reset_sweep");
        end

        cycle(1'b1, 1'b1, 8'h05, 16'hBEEF, 1'b0, 9'h000, "write_beef");
        read_settle(9'h00A, 8'hEF, "rd_0A");
        read_settle(9'h00B, 8'hBE, "rd_0B");

        cycle(1'b1, 1'b0, 8'h05, 16'h1234, 1'b0, 9'h000, "we0_write");
        cycle(1'b0, 1'b1, 8'h05, 16'h1234, 1'b0, 9'h000, "ena0_write");
        read_settle(9'h00A, 8'hEF, "nowr_0A");
        read_settle(9'h00B, 8'hBE, "nowr_0B");

        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 9'($urandom_range(0, 511)), "hold");
            check("hold_const", doB, 8'hBE);
        end

        cycle(1'b1, 1'b1, 8'h10, 16'hA55A, 1'b1, 9'h020, "collide");
        cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 9'h020, "collide_drain");
        check("collide_old", doB, 8'h00);
        read_settle(9'h020, 8'h5A, "collide_new");
        read_settle(9'h021, 8'hA5, "collide_hi");

        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 16'($urandom),
                  1'($urandom_range(0, 3) != 0), 9'($urandom_range(0, 511)), "random");
        end

        cycle(1'b1, 1'b1, 8'h33, 16'hC0DE, 1'b1, 9'h00A, "pre_reset_write");
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_doB", doB, 8'h00);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        read_settle(9'h00A, 8'h00, "post_rst_0A");
        read_settle(9'h00B, 8'h00, "post_rst_0B");
        read_settle(9'h066, 8'h00, "post_rst_66");
        read_settle(9'h067, 8'h00, "post_rst_67");
        read_settle(9'h020, 8'h00, "post_rst_20");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
